mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Consumer side of the EX/MEM pipeline register: the LEGv8 MEM stage.
//  Takes the EX/MEM outputs and resolves branches (PCSrc, target).
//  Runs load/store through a req/ack data-memory port with variable latency; stalls upstream while waiting.
//  Drives the registered MEM/WB outputs consumed by writeback.
// PARAMETERS
//  DATA_W          64   data/address width
//  REG_W           5    register index width
//  TIMEOUT_CYCLES  16   WAIT cycles without ack before abort (>=1)
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       synchronous, active-high reset
//  add_result     in   DATA_W  branch target from EX/MEM
//  alu_result     in   DATA_W  ALU result / memory address
//  zero           in   1       ALU zero flag
//  read2          in   DATA_W  store data
//  write_reg      in   REG_W   destination register
//  branch         in   1       conditional branch (CBZ)
//  uncBranch      in   1       unconditional branch (B)
//  memread        in   1       load
//  memwrite       in   1       store
//  regWrite       in   1       WB control
//  memtoReg       in   1       WB control
//  dmem_req       out  1       memory request, held until ack/abort
//  dmem_we        out  1       1 = write
//  dmem_addr      out  DATA_W  latched address
//  dmem_wdata     out  DATA_W  latched store data
//  dmem_rdata     in   DATA_W  load data, valid with dmem_ack
//  dmem_ack       in   1       one-cycle completion pulse
//  stall          out  1       hold IF..EX/MEM this cycle (combinational)
//  PCSrc          out  1       take branch (combinational)
//  Branch_target  out  DATA_W  = add_result
//  Mem_error      out  1       sticky timeout flag
//  Read_data      out  DATA_W  MEM/WB: load data
//  Alu_result     out  DATA_W  MEM/WB: ALU result
//  Write_reg      out  REG_W   MEM/WB: destination
//  RegWrite       out  1       MEM/WB: WB control
//  MemtoReg       out  1       MEM/WB: WB control
//  Valid          out  1       MEM/WB holds a real instruction
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0; all registered outputs 0, incl. dmem_req/we/addr/wdata, Mem_error.
//  Reset during WAIT: dmem_req low the cycle after reset; pending op discarded, no MEM/WB write.
//  FSM states IDLE and WAIT:
//  - IDLE, memread|memwrite=1: latch addr=alu_result, wdata=read2, we=memwrite -> WAIT.
//  - IDLE: no memory op means no transition.
//  - WAIT: dmem_req=1, addr/wdata/we stable. Each cycle without ack increments the counter.
//  - WAIT, dmem_ack=1: capture dmem_rdata -> Read_data (stores: 0); drop req; -> IDLE.
//  - WAIT, counter==TIMEOUT_CYCLES-1, no ack: abort; Mem_error<=1 (sticky until reset); Read_data<=0; -> IDLE.
//  Ack and timeout in the same cycle: ack wins.
//  memread&memwrite both set: treated as store.
//  dmem_ack in IDLE: ignored.
//  stall = (memread|memwrite) & ~(state==WAIT & (dmem_ack | timeout)).
//  Latency: non-memory op 1 cycle; memory op >= 2 cycles (IDLE cycle + ack cycle).
//  MEM/WB register, each edge:
//  - stall=0: load write_reg, alu_result, regWrite, memtoReg; Valid<=1.
//  - stall=1: bubble; RegWrite<=0, Valid<=0, other fields hold.
//  PCSrc = (uncBranch | (branch & zero)) & ~stall. Branch_target = add_result, pass-through.
//  Branch ops never carry memread/memwrite; if they do, PCSrc is asserted only in the completing cycle.
//  Write_reg=31 forwarded unchanged; the register file handles XZR.
// TESTING
//  1. Reset 2 cycles mid-WAIT -> dmem_req=0 next cycle, all outputs 0, Valid=0, Mem_error=0.
//  2. Load: alu_result=0x40, memread=1, regWrite=memtoReg=1; ack after 3 WAIT cycles, rdata=0xDEAD
//     -> stall high 4 cycles; dmem_addr=0x40; bubbles (Valid=0) then one cycle Read_data=0xDEAD, RegWrite=1, Valid=1.
//  3. Store: alu_result=0x80, read2=0x1234, memwrite=1; ack first WAIT cycle
//     -> dmem_we=1, dmem_wdata=0x1234, stall high 1 cycle, RegWrite=0.
//  4. Branches, add_result=0x100:
//     - branch=1, zero=1 -> PCSrc=1, Branch_target=0x100 same cycle.
//     - branch=1, zero=0 -> PCSrc=0.
//     - uncBranch=1 -> PCSrc=1.
//  5. Timeout: memread=1, ack never -> after 16 WAIT cycles stall drops, Read_data=0, Mem_error=1;
//     Mem_error persists through later ops until reset.
//  6. R-type: alu_result=0x7, write_reg=3, regWrite=1 -> next edge Alu_result=0x7, Write_reg=3, Valid=1; stall never high.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port of the MEM stage.
// The stage is the master: it presents a latched request and waits for a
// one-cycle acknowledge pulse that also qualifies the read data.
interface mem_access_stage_if #(
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: consumes the EX/MEM register, resolves branches,
// runs loads/stores over a variable-latency req/ack data-memory port
// (with a timeout abort), stalls upstream while a memory op is pending
// and drives the registered MEM/WB outputs for writeback.
module mem_access_stage #(
    parameter int DATA_W         = 64,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    // EX/MEM inputs
    input  logic [DATA_W-1:0]    add_result,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 zero,
    input  logic [DATA_W-1:0]    read2,
    input  logic [REG_W-1:0]     write_reg,
    input  logic                 branch,
    input  logic                 uncBranch,
    input  logic                 memread,
    input  logic                 memwrite,
    input  logic                 regWrite,
    input  logic                 memtoReg,
    // data-memory port (interface DATA_W must match this module's DATA_W)
    mem_access_stage_if.master   dmem,
    // pipeline control
    output logic                 stall,
    output logic                 PCSrc,
    output logic [DATA_W-1:0]    Branch_target,
    output logic                 Mem_error,
    // MEM/WB register
    output logic [DATA_W-1:0]    Read_data,
    output logic [DATA_W-1:0]    Alu_result,
    output logic [REG_W-1:0]     Write_reg,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 Valid
);

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               req_r;
    logic               we_r;
    logic [DATA_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               mem_error_r;
    logic [DATA_W-1:0]  read_data_r;

    logic [DATA_W-1:0]  alu_result_r;
    logic [REG_W-1:0]   write_reg_r;
    logic               reg_write_r;
    logic               memto_reg_r;
    logic               valid_r;

    logic               mem_op_s;
    logic               in_wait_s;
    logic               ack_s;
    logic               timeout_s;
    logic               done_s;
    logic               stall_s;
    logic               take_s;

    // Classify the current cycle: pending memory op, ack seen, timeout reached.
    // An ack outside WAIT is meaningless and is masked here.
    always_comb begin
        mem_op_s  = memread | memwrite;
        in_wait_s = (state_r == ST_WAIT);
        ack_s     = in_wait_s & dmem.ack;
        if (in_wait_s && (cnt_r == CNT_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        done_s = ack_s | timeout_s;
    end

    // Stall upstream until the memory op completes; branches only redirect
    // the PC in the cycle the instruction actually leaves this stage.
    always_comb begin
        stall_s = mem_op_s & ~done_s;
        take_s  = (uncBranch | (branch & zero)) & ~stall_s;
    end

    // Memory access FSM: latch the request in IDLE, hold it in WAIT until
    // ack (wins over timeout) or timeout abort; result lands in Read_data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {DATA_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            mem_error_r <= 1'b0;
            read_data_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (mem_op_s) begin
                        // load+store together is handled as a store
                        state_r <= ST_WAIT;
                        req_r   <= 1'b1;
                        we_r    <= memwrite;
                        addr_r  <= alu_result;
                        wdata_r <= read2;
                    end else begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (dmem.ack) begin
                        read_data_r <= we_r ? {DATA_W{1'b0}} : dmem.rdata;
                        req_r       <= 1'b0;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_IDLE;
                    end else if (timeout_s) begin
                        mem_error_r <= 1'b1;
                        read_data_r <= {DATA_W{1'b0}};
                        req_r       <= 1'b0;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // MEM/WB register: advance when not stalled, otherwise insert a bubble
    // (RegWrite/Valid cleared, payload fields held).
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_result_r <= {DATA_W{1'b0}};
            write_reg_r  <= {REG_W{1'b0}};
            reg_write_r  <= 1'b0;
            memto_reg_r  <= 1'b0;
            valid_r      <= 1'b0;
        end else if (!stall_s) begin
            alu_result_r <= alu_result;
            write_reg_r  <= write_reg;
            reg_write_r  <= regWrite;
            memto_reg_r  <= memtoReg;
            valid_r      <= 1'b1;
        end else begin
            reg_write_r  <= 1'b0;
            valid_r      <= 1'b0;
        end
    end

    assign dmem.req      = req_r;
    assign dmem.we       = we_r;
    assign dmem.addr     = addr_r;
    assign dmem.wdata    = wdata_r;

    assign stall         = stall_s;
    assign PCSrc         = take_s;
    assign Branch_target = add_result;
    assign Mem_error     = mem_error_r;

    assign Read_data     = read_data_r;
    assign Alu_result    = alu_result_r;
    assign Write_reg     = write_reg_r;
    assign RegWrite      = reg_write_r;
    assign MemtoReg      = memto_reg_r;
    assign Valid         = valid_r;

endmodule
